// File: rtl/aemb_dwb_arb.sv
// Two-master round-robin arbiter for the AEMB data Wishbone bus.
// Optional watchdog on hung slave cycles: define AEMB_DWB_TMO_EN.
module aemb_dwb_arb #(
   parameter int unsigned AW   = 30,
   parameter int unsigned DW   = 32,
   parameter int unsigned TMOW = 4
) (
   input  logic              gclk,
   input  logic              grst_n,
   input  logic [AW+1:2]     m0_adr_i,
   input  logic [DW-1:0]     m0_dat_i,
   input  logic [DW/8-1:0]   m0_sel_i,
   input  logic              m0_stb_i,
   input  logic              m0_wre_i,
   output logic [DW-1:0]     m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   input  logic [AW+1:2]     m1_adr_i,
   input  logic [DW-1:0]     m1_dat_i,
   input  logic [DW/8-1:0]   m1_sel_i,
   input  logic              m1_stb_i,
   input  logic              m1_wre_i,
   output logic [DW-1:0]     m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic [AW+1:2]     dwb_adr_o,
   output logic [DW-1:0]     dwb_dat_o,
   output logic [DW/8-1:0]   dwb_sel_o,
   output logic              dwb_stb_o,
   output logic              dwb_wre_o,
   input  logic [DW-1:0]     dwb_dat_i,
   input  logic              dwb_ack_i,
   output logic [1:0]        gnt_o
);

   // Counter value seen in the last allowed granted cycle (2**TMOW-1 cycles in total).
   localparam logic [TMOW-1:0] TMOLIM = TMOW'((2 ** TMOW) - 2);

   typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

   state_t          rState, xState;
   logic            rLast, xLast;
   logic [TMOW-1:0] rTmo;
   logic            wOwn, wStb, wTmo;

   assign wOwn = (rState == GNT1);
   assign wStb = wOwn ? m1_stb_i : m0_stb_i;
   assign wTmo = (rTmo == TMOLIM);

`ifdef AEMB_DWB_TMO_EN
   logic [TMOW-1:0] xTmo;

   // Watchdog counts granted cycles; clears whenever the bus returns to IDLE.
   always_comb begin
      xTmo = '0;
      if (rState != IDLE && xState != IDLE) xTmo = rTmo + TMOW'(1);
   end

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) rTmo <= '0;
      else         rTmo <= xTmo;
   end
`else
   // All-ones never equals the terminal count, so no timeout can fire.
   assign rTmo = '1;
`endif

   // State register.
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         rState <= IDLE;
         rLast  <= 1'b1;
      end else begin
         rState <= xState;
         rLast  <= xLast;
      end
   end

   // Next state: rLast remembers the most recently completed master (1 = m1).
   always_comb begin
      xState = rState;
      xLast  = rLast;
      case (rState)
         IDLE: begin
            if (m0_stb_i && m1_stb_i) xState = rLast ? GNT0 : GNT1;
            else if (m0_stb_i)        xState = GNT0;
            else if (m1_stb_i)        xState = GNT1;
         end
         GNT0, GNT1: begin
            if (dwb_ack_i) begin
               xState = IDLE;
               xLast  = wOwn;
            end else if (!wStb) begin
               xState = IDLE;
            end else if (wTmo) begin
               xState = IDLE;
               xLast  = wOwn;
            end
         end
         default: xState = IDLE;
      endcase
   end

   // Output mux from registered grant; everything parks at zero in IDLE.
   always_comb begin
      dwb_adr_o = '0;
      dwb_dat_o = '0;
      dwb_sel_o = '0;
      dwb_stb_o = 1'b0;
      dwb_wre_o = 1'b0;
      m0_ack_o  = 1'b0;
      m1_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_err_o  = 1'b0;
      gnt_o     = 2'b00;
      case (rState)
         GNT0: begin
            dwb_adr_o = m0_adr_i;
            dwb_dat_o = m0_dat_i;
            dwb_sel_o = m0_sel_i;
            dwb_stb_o = m0_stb_i;
            dwb_wre_o = m0_wre_i;
            m0_ack_o  = dwb_ack_i;
            m0_err_o  = wTmo & m0_stb_i & ~dwb_ack_i;
            gnt_o     = 2'b01;
         end
         GNT1: begin
            dwb_adr_o = m1_adr_i;
            dwb_dat_o = m1_dat_i;
            dwb_sel_o = m1_sel_i;
            dwb_stb_o = m1_stb_i;
            dwb_wre_o = m1_wre_i;
            m1_ack_o  = dwb_ack_i;
            m1_err_o  = wTmo & m1_stb_i & ~dwb_ack_i;
            gnt_o     = 2'b10;
         end
         default: ;
      endcase
   end

   assign m0_dat_o = dwb_dat_i;
   assign m1_dat_o = dwb_dat_i;

endmodule
